// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two client request ports, the RAM port and the FSM debug state.
// Handshake: a client raises reqN with rw/addr/wdata valid and holds it until ackN (one-cycle pulse); inputs are sampled only in the granting cycle.
interface ram_arbiter_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 1
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [WIDTH-1:0]  wdata0;
  logic              ack0;
  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [WIDTH-1:0]  wdata1;
  logic              ack1;
  logic [WIDTH-1:0]  rdata;
  logic              busy;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din;
  logic [WIDTH-1:0]  ram_dout;
  logic [1:0]        fsm_state;

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_dout,
    input  ack0, ack1, rdata, busy, ram_rw, ram_addr, ram_din, fsm_state
  );

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_dout,
    output ack0, ack1, rdata, busy, ram_rw, ram_addr, ram_din, fsm_state
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-client arbiter/sequencer for a small shared RAM (IDLE -> ACCESS -> DONE).
// Optional ARB_SCRUB_EN: after reset the RAM is zero-filled, one word per cycle, before serving clients.
module ram_arbiter #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 1
) (
  input logic          clk,
  input logic          clear_n,
  ram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
`ifdef ARB_SCRUB_EN
  localparam logic [1:0] SCRUB       = 2'd3;
  localparam logic [1:0] RESET_STATE = SCRUB;
`else
  localparam logic [1:0] RESET_STATE = IDLE;
`endif

  logic [1:0]        state;
  logic              last_grant;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic [WIDTH-1:0]  rdata_q;
  logic              any_req;
  logic              win;
`ifdef ARB_SCRUB_EN
  logic [ADDR_W-1:0] scrub_addr;
`endif

  // On a tie the client that was not granted last wins; last_grant also names the client acked in DONE.
  assign any_req = bus.req0 | bus.req1;
  assign win     = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= RESET_STATE;
      last_grant <= 1'b1;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
`ifdef ARB_SCRUB_EN
      scrub_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            last_grant <= win;
            lat_rw     <= win ? bus.rw1    : bus.rw0;
            lat_addr   <= win ? bus.addr1  : bus.addr0;
            lat_wdata  <= win ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          if (!lat_rw) rdata_q <= bus.ram_dout;
          state <= DONE;
        end
        DONE: state <= IDLE;
`ifdef ARB_SCRUB_EN
        SCRUB: begin
          scrub_addr <= scrub_addr + 1'b1;
          if (&scrub_addr) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = (state == DONE) & ~last_grant;
  assign bus.ack1      = (state == DONE) & last_grant;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = clear_n & (state != IDLE);
  assign bus.fsm_state = state;

`ifdef ARB_SCRUB_EN
  // Reset parks the FSM in SCRUB, so the strobe is gated to stay low while clear_n is asserted.
  assign bus.ram_rw   = clear_n & (((state == ACCESS) & lat_rw) | (state == SCRUB));
  assign bus.ram_addr = (state == SCRUB) ? scrub_addr : lat_addr;
  assign bus.ram_din  = (state == SCRUB) ? '0 : lat_wdata;
`else
  assign bus.ram_rw   = (state == ACCESS) & lat_rw;
  assign bus.ram_addr = lat_addr;
  assign bus.ram_din  = lat_wdata;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared small RAM (the 2x4 word RAM built from 1x4 cells, plus its wider variants).
- Accepts read/write requests from two independent clients and grants the RAM to one client at a time, round-robin.
- Drives the RAM's readWrite/address/data lines for exactly one access cycle.
- Returns an ack pulse with captured read data.
- Sits between the RAM and client logic such as test sequencers and small CPUs.

Parameters:
- WIDTH, 4: data word width in bits.
- ADDR_W, 1: address width; RAM depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- clear_n  input  1  asynchronous active-low reset.
- req0  input  1  client 0 request; held high until ack0.
- rw0  input  1  client 0 op: 1 = write, 0 = read.
- addr0  input  ADDR_W  client 0 address.
- wdata0  input  WIDTH  client 0 write data.
- ack0  output  1  one-cycle completion pulse to client 0.
- req1, rw1, addr1, wdata1, ack1: same as client 0, for client 1.
- rdata  output  WIDTH  read data of the last completed read; valid while ackN=1 and held afterwards.
- busy  output  1  high whenever the FSM is not in IDLE.
- ram_rw  output  1  RAM readWrite; 1 = write strobe.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  WIDTH  RAM write data.
- ram_dout  input  WIDTH  RAM combinational read data.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - FSM goes to IDLE (or SCRUB, see Optional Feature).
  - ack0=ack1=0, rdata=0, busy=0, ram_rw=0, ram_addr=0, ram_din=0.
  - last_grant=1, so client 0 wins the first tie.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one reqN is high, grant it.
  - If both are high, grant the client not equal to last_grant.
  - On grant: latch rw, addr and wdata of the winner into internal registers, set last_grant=winner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_din are driven from the latched values.
  - ram_rw=1 only if the latched op is a write; otherwise 0.
  - For a read, ram_dout is sampled into rdata at the end of this cycle.
  - Next state is DONE.
- DONE (exactly 1 cycle):
  - ack of the granted client is high; ram_rw=0.
  - Next state is IDLE.
- Latency: req sampled high at edge N -> ACCESS during cycle N+1 -> ack high during cycle N+2.
- Throughput: one transaction per 3 cycles. When both clients request continuously, grants alternate 0,1,0,1.
- Requests arriving while busy=1 wait; they are never lost or merged.
- Client protocol: inputs are sampled only at grant. Changing addr/wdata after grant has no effect on the current transaction.
- req dropped after grant: the transaction still completes and the ack is still issued.
- req held high after ack: treated as a new request at the next IDLE evaluation, with round-robin applied.
- ack0 and ack1 are never high in the same cycle, and each is high for at most 1 cycle per transaction.
- ram_rw is high in at most one cycle per write and never during reset.
- Reset mid-transaction aborts immediately:
  - No ack is issued.
  - ram_rw drops asynchronously.
  - Any pending write is not performed if reset is asserted before the ACCESS clock edge.
- Address wrap: none needed. addr is exactly ADDR_W bits, so every value is a valid location.

Optional Feature:
- Macro: ARB_SCRUB_EN.
- Defined:
  - After reset release, the FSM enters SCRUB instead of IDLE.
  - SCRUB writes 0 to addresses 0..2**ADDR_W-1, one per cycle (ram_rw=1, ram_din=0), then goes to IDLE.
  - busy=1 throughout SCRUB; requests are held off and no ack is issued.
  - Scrub time = 2**ADDR_W cycles.
  - Reset during SCRUB restarts it from address 0.
- Undefined: no SCRUB state; the RAM contents after reset are whatever the RAM holds.

Test Plan:
1. Reset, then req0=1, rw0=1, addr0=0, wdata0=4'b1100 -> ram_rw=1 with ram_addr=0, ram_din=1100 in cycle N+1; ack0=1 in cycle N+2; ack1 stays 0.
2. After test 1: req1=1, rw1=0, addr1=0 -> ack1 pulse with rdata=1100. Then client 0 writes 4'b0011 to addr 1 and client 1 reads addr 1 -> rdata=0011.
3. req0 and req1 both held high (reads, addr 0 and 1) -> ack order 0,1,0,1; acks 3 cycles apart; never simultaneous.
4. Grant client 0 for a write, drop req0 and change wdata0 in the ACCESS cycle -> the originally latched value is written and ack0 still pulses.
5. Assert clear_n=0 during ACCESS of a write -> ram_rw drops immediately, no ack, busy=0. A following read of that address returns the old data (or 0 with ARB_SCRUB_EN).
6. With ARB_SCRUB_EN and ADDR_W=1: after reset release busy=1 for 2 cycles with ram_rw=1 and addresses 0 then 1; a req0 held during this time is acked only after SCRUB; reads of both addresses return 0000.
